// File: rtl/matrix_dot_sequencer.sv
// matrix_dot_sequencer: buffers one job of A/B operand beats, then streams
// them back-to-back into a downstream MatrixMul*Cores dot-product core.
// After streaming it adds one zero-product DRAIN cycle, captures the
// core's result and holds it until the consumer accepts it.
// Optional feature: define MATRIX_SEQ_CYCLE_CNT_EN to add OUT_CYCLES, a
// 16-bit saturating count of the START-high cycles of the job.
//
// Handshakes: a beat transfers on a rising edge where IN_VALID && IN_READY;
// a result transfers on a rising edge where OUT_VALID && OUT_READY. Once
// OUT_VALID is raised, it and OUT_DATA stay unchanged until the transfer.
module matrix_dot_sequencer #(
  parameter int DWIDTH = 32,
  parameter int LANES  = 1,
  parameter int DEPTH  = 16
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [LANES*DWIDTH-1:0] IN_A,
  input  logic [LANES*DWIDTH-1:0] IN_B,
  input  logic                    IN_LAST,
  output logic                    START,
  output logic [LANES*DWIDTH-1:0] STREAM_A,
  output logic [LANES*DWIDTH-1:0] STREAM_B,
  input  logic [DWIDTH-1:0]       STREAM_O,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
`ifdef MATRIX_SEQ_CYCLE_CNT_EN
  output logic [15:0]             OUT_CYCLES,
`endif
  output logic [DWIDTH-1:0]       OUT_DATA
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = LANES * DWIDTH;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_n;
  logic [CW-1:0] r_rp;
  logic [BW-1:0] r_buf_a [DEPTH];
  logic [BW-1:0] r_buf_b [DEPTH];
  logic          r_in_ready;
  logic          r_start;
  logic [BW-1:0] r_stream_a;
  logic [BW-1:0] r_stream_b;
  logic          r_out_valid;
  logic [DWIDTH-1:0] r_out_data;

  logic          w_accept;
  logic          w_last_beat;
  logic [CW-1:0] w_rp_next;

  assign w_accept    = (r_state == LOAD) && IN_VALID && r_in_ready;
  assign w_last_beat = IN_LAST || (r_cnt == CW'(DEPTH - 1));
  assign w_rp_next   = r_rp + CW'(1);

  // Operand buffer: plain storage, written only by accepted beats.
  always_ff @(posedge CLOCK) begin
    if (w_accept) begin
      r_buf_a[r_cnt[AW-1:0]] <= IN_A;
      r_buf_b[r_cnt[AW-1:0]] <= IN_B;
    end
  end

  // Job FSM with registered outputs; the stream word for the next cycle is
  // prefetched so STREAM_A/B come straight from flops.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state     <= LOAD;
      r_cnt       <= '0;
      r_n         <= '0;
      r_rp        <= '0;
      r_in_ready  <= 1'b1;
      r_start     <= 1'b0;
      r_stream_a  <= '0;
      r_stream_b  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_accept) begin
            r_cnt <= r_cnt + CW'(1);
            if (w_last_beat) begin
              r_state    <= STREAM;
              r_n        <= r_cnt + CW'(1);
              r_rp       <= '0;
              r_in_ready <= 1'b0;
              r_start    <= 1'b1;
              // A one-beat job is being written this very edge, so bypass.
              if (r_cnt == '0) begin
                r_stream_a <= IN_A;
                r_stream_b <= IN_B;
              end else begin
                r_stream_a <= r_buf_a[0];
                r_stream_b <= r_buf_b[0];
              end
            end
          end
        end
        STREAM: begin
          r_rp <= w_rp_next;
          if (w_rp_next == r_n) begin
            r_state    <= DRAIN;
            r_stream_a <= '0;
            r_stream_b <= '0;
          end else begin
            r_stream_a <= r_buf_a[w_rp_next[AW-1:0]];
            r_stream_b <= r_buf_b[w_rp_next[AW-1:0]];
          end
        end
        DRAIN: begin
          r_state     <= HOLD;
          r_start     <= 1'b0;
          r_out_data  <= STREAM_O;
          r_out_valid <= 1'b1;
        end
        HOLD: begin
          if (OUT_READY) begin
            r_state     <= LOAD;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

`ifdef MATRIX_SEQ_CYCLE_CNT_EN
  logic [15:0] r_cycles;

  // START-high cycle counter: cleared when a job starts streaming,
  // saturating at all-ones.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_cycles <= '0;
    end else if (w_accept && w_last_beat) begin
      r_cycles <= '0;
    end else if (r_start && (r_cycles != 16'hFFFF)) begin
      r_cycles <= r_cycles + 16'd1;
    end
  end

  assign OUT_CYCLES = r_cycles;
`endif

  assign IN_READY  = r_in_ready;
  assign START     = r_start;
  assign STREAM_A  = r_stream_a;
  assign STREAM_B  = r_stream_b;
  assign OUT_VALID = r_out_valid;
  assign OUT_DATA  = r_out_data;

endmodule
